// File: rtl/wts_channel_volume_mux_pkg.sv
// Shared widths, unity-gain constant, channel index type and the saturation
// classifier used by the volume datapath and the frame accumulator.
package wts_volume_pkg;

   localparam int NCH_DEF   = 5;
   localparam int SW_DEF    = 8;
   localparam int EW_DEF    = 9;
   localparam int VW_DEF    = 4;
   localparam int UNITY_DEF = 2 ** (EW_DEF - 1);

   typedef logic [$clog2(NCH_DEF)-1:0] ch_idx_t;

   typedef enum logic [1:0] {
      SAT_NONE = 2'b00,
      SAT_HI   = 2'b01,
      SAT_LO   = 2'b10
   } sat_e;

   // Index width that stays at least one bit even for a single channel
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

   // Classifies v against the signed range of a w-bit result
   function automatic sat_e sat(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 32'd1));
      if (v > hi) begin
         return SAT_HI;
      end else if (v < lo) begin
         return SAT_LO;
      end else begin
         return SAT_NONE;
      end
   endfunction

endpackage

// File: rtl/wts_channel_volume_mux_if.sv
// Slot, volume-register and result bundle between the wave-table sequencer and
// the multiplexed volume stage.
interface wts_channel_volume_mux_if
   import wts_volume_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int SW  = SW_DEF,
   parameter int EW  = EW_DEF,
   parameter int VW  = VW_DEF
);
   localparam int CW = idx_w(NCH);
   localparam int MW = SW + CW;

   logic                 in_valid;
   logic [CW-1:0]        in_ch;
   logic                 in_last;
   logic signed [SW-1:0] sram_q;
   logic [EW-1:0]        envelope;
   logic                 reg_we;
   logic [CW-1:0]        reg_ch;
   logic [VW-1:0]        reg_volume;
   logic                 ch_valid;
   logic [CW-1:0]        ch_idx;
   logic signed [SW-1:0] channel;
   logic                 mix_valid;
   logic signed [MW-1:0] mix_out;

   modport master (
      output in_valid, in_ch, in_last, sram_q, envelope, reg_we, reg_ch, reg_volume,
      input  ch_valid, ch_idx, channel, mix_valid, mix_out
   );

   modport slave (
      input  in_valid, in_ch, in_last, sram_q, envelope, reg_we, reg_ch, reg_volume,
      output ch_valid, ch_idx, channel, mix_valid, mix_out
   );

endinterface

// File: rtl/wts_channel_volume_mux_mul.sv
// Two-stage sample x envelope x volume datapath with floor shift and saturation.
// mark_i travels every cycle so frame markers survive dropped slots.
module wts_volume_mul
   import wts_volume_pkg::*;
#(
   parameter int SW = SW_DEF,
   parameter int EW = EW_DEF,
   parameter int VW = VW_DEF,
   parameter int TW = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   input  logic                 mark_i,
   input  logic [TW-1:0]        tag_i,
   input  logic signed [SW-1:0] sample_i,
   input  logic [EW-1:0]        env_i,
   input  logic [VW-1:0]        vol_i,
   output logic                 valid_o,
   output logic                 mark_o,
   output logic [TW-1:0]        tag_o,
   output logic signed [SW-1:0] res_o
);
   localparam int P1W = SW + EW + 1;
   localparam int P2W = P1W + VW + 1;
   localparam int SH  = EW - 1 + VW;

   logic signed [P1W-1:0] sx_s, ex_s, p1_d, p1_q;
   logic signed [P2W-1:0] p1x_s, vx_s, p2_s;
   logic signed [63:0]    shr_s;
   logic signed [SW-1:0]  res_d;
   logic [VW-1:0]         vol1_q;
   logic [TW-1:0]         tag1_q;
   logic                  valid1_q, mark1_q;

   // Stage 1 product: signed sample times zero-extended envelope
   always_comb begin
      sx_s = {{(EW + 1){sample_i[SW-1]}}, sample_i};
      ex_s = {{SW{1'b0}}, 1'b0, env_i};
      p1_d = sx_s * ex_s;
   end

   // Stage 2 product, arithmetic shift (floor) and clamp to sample range
   always_comb begin
      p1x_s = {{(VW + 1){p1_q[P1W-1]}}, p1_q};
      vx_s  = {{(P1W + 1){1'b0}}, vol1_q};
      p2_s  = p1x_s * vx_s;
      shr_s = $signed({{(64 - P2W){p2_s[P2W-1]}}, p2_s}) >>> SH;
      case (sat(shr_s, SW))
         SAT_HI:  res_d = {1'b0, {(SW - 1){1'b1}}};
         SAT_LO:  res_d = {1'b1, {(SW - 1){1'b0}}};
         default: res_d = shr_s[SW-1:0];
      endcase
   end

   // Stage 1 registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_q <= 1'b0;
         mark1_q  <= 1'b0;
         p1_q     <= {P1W{1'b0}};
         vol1_q   <= {VW{1'b0}};
         tag1_q   <= {TW{1'b0}};
      end else begin
         valid1_q <= valid_i;
         mark1_q  <= mark_i;
         if (valid_i) begin
            p1_q   <= p1_d;
            vol1_q <= vol_i;
            tag1_q <= tag_i;
         end
      end
   end

   // Stage 2 registers; result holds between valid slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         mark_o  <= 1'b0;
         tag_o   <= {TW{1'b0}};
         res_o   <= {SW{1'b0}};
      end else begin
         valid_o <= valid1_q;
         mark_o  <= mark1_q;
         if (valid1_q) begin
            tag_o <= tag1_q;
            res_o <= res_d;
         end
      end
   end

endmodule

// File: rtl/wts_channel_volume_mux.sv
// Time-multiplexed volume stage and frame mixer for NCH wave-table channels.
// Optional WTS_VOL_RAMP_EN: effective volume steps +-1 toward the register once per frame.
module wts_channel_volume_mux
   import wts_volume_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int SW  = SW_DEF,
   parameter int EW  = EW_DEF,
   parameter int VW  = VW_DEF
) (
   input logic               clk,
   input logic               nreset,
   wts_channel_volume_mux_if.slave bus
);
   localparam int CW = idx_w(NCH);
   localparam int MW = SW + CW;
   localparam int NV = 1 << CW;
   localparam logic [CW:0] NCH_L = (CW + 1)'(NCH);

   logic [VW-1:0]        vol_q [NV];
   logic [VW-1:0]        vol_d [NV];
   logic [VW-1:0]        eff_s [NV];
   logic [VW-1:0]        vol_sel_s;
   logic                 slot_ok_s, last_in_s;
   logic                 s2_valid_s, s2_mark_s;
   logic [CW-1:0]        s2_ch_s;
   logic signed [SW-1:0] s2_res_s;
   logic signed [63:0]   r_ext_s, acc_ext_s, sum_s;
   logic signed [MW-1:0] sum_sat_s, acc_d, acc_q, mix_out_d, mix_out_q;
   logic                 mix_valid_d, mix_valid_q;

   assign slot_ok_s = bus.in_valid && ({1'b0, bus.in_ch} < NCH_L);
   assign last_in_s = bus.in_valid && bus.in_last;
   assign vol_sel_s = eff_s[bus.in_ch];

   // Volume register file; a write is seen by slots from the next cycle on
   always_comb begin
      vol_d = vol_q;
      if (bus.reg_we && ({1'b0, bus.reg_ch} < NCH_L)) begin
         vol_d[bus.reg_ch] = bus.reg_volume;
      end else begin
         vol_d = vol_q;
      end
   end

   // Volume register state
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NV; i++) vol_q[i] <= {VW{1'b0}};
      end else begin
         vol_q <= vol_d;
      end
   end

`ifdef WTS_VOL_RAMP_EN
   logic [VW-1:0] eff_q [NV];
   logic [VW-1:0] eff_d [NV];

   // Ramp each effective volume one step toward its target per completed frame
   always_comb begin
      eff_d = eff_q;
      for (int i = 0; i < NV; i++) begin
         if (mix_valid_q && (eff_q[i] < vol_q[i])) begin
            eff_d[i] = eff_q[i] + {{(VW - 1){1'b0}}, 1'b1};
         end else if (mix_valid_q && (eff_q[i] > vol_q[i])) begin
            eff_d[i] = eff_q[i] - {{(VW - 1){1'b0}}, 1'b1};
         end else begin
            eff_d[i] = eff_q[i];
         end
      end
   end

   // Effective volume state
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NV; i++) eff_q[i] <= {VW{1'b0}};
      end else begin
         eff_q <= eff_d;
      end
   end

   assign eff_s = eff_q;
`else
   assign eff_s = vol_q;
`endif

   wts_volume_mul #(.SW(SW), .EW(EW), .VW(VW), .TW(CW)) u_mul (
      .clk      (clk),
      .rst_n    (nreset),
      .valid_i  (slot_ok_s),
      .mark_i   (last_in_s),
      .tag_i    (bus.in_ch),
      .sample_i (bus.sram_q),
      .env_i    (bus.envelope),
      .vol_i    (vol_sel_s),
      .valid_o  (s2_valid_s),
      .mark_o   (s2_mark_s),
      .tag_o    (s2_ch_s),
      .res_o    (s2_res_s)
   );

   assign r_ext_s   = s2_valid_s ? {{(64 - SW){s2_res_s[SW-1]}}, s2_res_s} : 64'sd0;
   assign acc_ext_s = {{(64 - MW){acc_q[MW-1]}}, acc_q};
   assign sum_s     = acc_ext_s + r_ext_s;

   // Frame accumulation; the marked slot publishes the sum and restarts from zero
   always_comb begin
      case (sat(sum_s, MW))
         SAT_HI:  sum_sat_s = {1'b0, {(MW - 1){1'b1}}};
         SAT_LO:  sum_sat_s = {1'b1, {(MW - 1){1'b0}}};
         default: sum_sat_s = sum_s[MW-1:0];
      endcase
      acc_d       = acc_q;
      mix_out_d   = mix_out_q;
      mix_valid_d = 1'b0;
      if (s2_mark_s) begin
         acc_d       = {MW{1'b0}};
         mix_out_d   = sum_sat_s;
         mix_valid_d = 1'b1;
      end else if (s2_valid_s) begin
         acc_d = sum_sat_s;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator and mix output registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         acc_q       <= {MW{1'b0}};
         mix_out_q   <= {MW{1'b0}};
         mix_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         mix_out_q   <= mix_out_d;
         mix_valid_q <= mix_valid_d;
      end
   end

   assign bus.ch_valid  = s2_valid_s;
   assign bus.ch_idx    = s2_ch_s;
   assign bus.channel   = s2_res_s;
   assign bus.mix_valid = mix_valid_q;
   assign bus.mix_out   = mix_out_q;

endmodule
